// File: rtl/fsm_pulse_monitor.sv
// fsm_pulse_monitor: counts upstream FSM strobes, measures inter-strobe intervals, watchdog and protocol checks
module fsm_pulse_monitor #(
    parameter int CNT_W   = 8,
    parameter int INT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [INT_W-1:0] last_int,
    output logic [INT_W-1:0] min_int,
    output logic [INT_W-1:0] max_int,
    output logic             int_valid,
    output logic             timeout,
    output logic             protocol_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] STALL   = 2'd3;
    localparam logic [INT_W-1:0] TO_V  = INT_W'(TIMEOUT);
    localparam logic [INT_W-1:0] ONE_V = INT_W'(1);
    logic [1:0]       state_q, state_d;
    logic [INT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [INT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
    logic             valid_q, valid_d, perr_q, perr_d, prev_q, prev_d;
    logic             acc, b2b;
    logic [INT_W-1:0] timer_inc;
    // next-state: clear beats disable beats strobe/timer; a strobe right after a high sample is a violation, not a strobe
    always_comb begin
        acc       = en & pulse_in & ~prev_q;
        b2b       = en & pulse_in & prev_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        min_d     = min_q;
        max_d     = max_q;
        perr_d    = perr_q;
        valid_d   = 1'b0;
        prev_d    = en & pulse_in;
        if (clr) begin
            state_d = en ? ARMED : IDLE;
            timer_d = en ? ONE_V : timer_q;
            cnt_d   = '0;
            last_d  = '0;
            min_d   = '1;
            max_d   = '0;
            perr_d  = 1'b0;
            prev_d  = 1'b0;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            perr_d = perr_q | b2b;
            if (acc) begin
                state_d = MEASURE;
                timer_d = ONE_V;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (state_q == MEASURE || state_q == STALL) begin
                    valid_d = 1'b1;
                    last_d  = timer_q;
                    min_d   = (timer_q < min_q) ? timer_q : min_q;
                    max_d   = (timer_q > max_q) ? timer_q : max_q;
                end
            end else if (state_q == IDLE) begin
                state_d = ARMED;
                timer_d = ONE_V;
            end else begin
                timer_d = timer_inc;
                state_d = (state_q != STALL && timer_q == TO_V) ? STALL : state_q;
            end
        end
    end
    // state and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            min_q   <= min_d;
            max_q   <= max_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            prev_q  <= prev_d;
        end
    end
    assign pulse_cnt    = cnt_q;
    assign last_int     = last_q;
    assign min_int      = min_q;
    assign max_int      = max_q;
    assign int_valid    = valid_q;
    assign timeout      = (state_q == STALL);
    assign protocol_err = perr_q;
endmodule

// File: doc/fsm_pulse_monitor.md
# fsm_pulse_monitor

Downstream monitor for the single-cycle `out` strobe produced by the x/y control FSM, which pulses whenever that FSM passes through its s3 state. The block counts strobes and measures the cycle distance between consecutive strobes, keeping last/min/max statistics. It also flags a stalled FSM through a watchdog timeout and flags protocol violations: the upstream FSM can never strobe on two consecutive cycles. All outputs are registered for direct connection to a status/debug register bank.

## Interface
- `CNT_W`, 8: width of pulse counter (saturating).
- `INT_W`, 8: width of interval measurements (saturating).
- `TIMEOUT`, 32: cycles without a strobe before `timeout` asserts; legal range 2..2^INT_W-1.

- `clk`  in  1  clock; one clock domain, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  monitoring enable (level).
- `clr`  in  1  synchronous clear of statistics and flags (one-cycle or level).
- `pulse_in`  in  1  strobe from upstream FSM `out`.
- `pulse_cnt`  out  CNT_W  number of accepted strobes.
- `last_int`  out  INT_W  most recent interval, in cycles.
- `min_int`  out  INT_W  smallest interval since clear.
- `max_int`  out  INT_W  largest interval since clear.
- `int_valid`  out  1  one-cycle strobe: new interval captured.
- `timeout`  out  1  level; watchdog expired.
- `protocol_err`  out  1  sticky; back-to-back strobe seen.

## Operation
- Accepted strobe: `pulse_in`=1 while `en`=1 and `pulse_in` was 0 in the previous cycle. The previous-cycle sample is registered and cleared by `rst`/`clr`.
- States:
  - IDLE: `en`=0.
  - ARMED: enabled, no strobe yet since clear/enable.
  - MEASURE: at least one strobe seen.
  - STALL: watchdog expired.
- Transitions:
  - IDLE->ARMED on `en`.
  - ARMED->MEASURE on an accepted strobe.
  - MEASURE->MEASURE on an accepted strobe.
  - ARMED or MEASURE->STALL when the timer reaches TIMEOUT.
  - STALL->MEASURE on an accepted strobe.
  - Any state->IDLE when `en`=0.
- Timer (INT_W bits, saturating):
  - Loads 1 on an accepted strobe; otherwise increments each enabled cycle.
  - Loads 1 on entry to ARMED.
  - Holds in IDLE.
- Strobe in MEASURE or STALL:
  - `last_int` <= timer; `min_int` <= min(`min_int`, timer); `max_int` <= max(`max_int`, timer).
  - `int_valid` pulses.
- Strobe in ARMED: no interval is captured and `int_valid` stays 0.
- Every accepted strobe increments `pulse_cnt`, which saturates at 2^CNT_W-1.
- Interval meaning: strobes at cycles t and t+k give interval k. The minimum legal k from the upstream FSM is 3.
- `timeout` is 1 exactly while in STALL.
- `protocol_err` sets when `pulse_in`=1 on two consecutive enabled cycles. The second cycle is not counted. The flag stays set until `clr`/`rst`.
- Priority: `rst` > `clr` > `en`=0 > strobe/timer.
  - `clr` resets all statistics and flags, and sets state to ARMED if `en`, else IDLE.
  - A strobe coincident with `clr` is ignored.
- Dropping `en` holds all statistics. Re-enabling enters ARMED, so the first strobe after re-enable captures no interval.

## Timing
- Reset values:
  - IDLE state; timer 0.
  - `pulse_cnt`=0, `last_int`=0, `min_int`=all ones, `max_int`=0.
  - `int_valid`=0, `timeout`=0, `protocol_err`=0.
- Latency:
  - A strobe sampled at edge N is reflected on all outputs after edge N; `int_valid` is high for exactly that one cycle.
  - `timeout` rises one cycle after the timer value equals TIMEOUT. It falls one cycle after the recovering strobe.
- No combinational path from inputs to outputs.
- Saturation: the timer stops at 2^INT_W-1, so the captured interval is 2^INT_W-1 for any longer gap. `timeout` still asserts at TIMEOUT.

## Test plan
- Reset and enable; drive strobes at cycles 10, 13, 18 -> `pulse_cnt`=3; `int_valid` twice; `last_int`=5, `min_int`=3, `max_int`=5; first strobe captures nothing.
- Connect the x/y FSM with x=1, y=1 constant -> strobe every 3 cycles; after 10 strobes `pulse_cnt`=10, min=max=last=3, `protocol_err`=0, `timeout`=0.
- Enable with no strobe for TIMEOUT=32 cycles -> `timeout`=1 thereafter. Then a strobe at gap 40 -> `last_int`=40; `timeout` drops next cycle.
- Hold `pulse_in` high 2 cycles -> `pulse_cnt` +1 only; `protocol_err`=1 and stays set until `clr`; `clr` together with a strobe -> all stats at reset values, `pulse_cnt`=0.
- Gap of 300 cycles with INT_W=8 -> `last_int`=255. Then 256 strobes with CNT_W=8 -> `pulse_cnt`=255.
- Deassert `en` mid-run -> outputs hold; strobes ignored. Reassert `en` -> first strobe gives no `int_valid`. Assert `rst` mid-interval -> all reset values on the next cycle.
